subckt_toggle_monitor: RTL
==========================

SUBCKT_TOGGLE_MONITOR -- requirements
Module: subckt_toggle_monitor

Interface
REQ-001 The block SHALL have parameter IN_W, default 4, meaning the width of the sub-circuit input vector being monitored.
REQ-002 The block SHALL have parameter CNT_W, default 16, meaning the width of every counter and of win_len.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 The block SHALL have port start, input, 1 bit: single-cycle request to begin a measurement window.
REQ-006 The block SHALL have port win_len, input, CNT_W bits: number of samples per window, sampled on accepted start.
REQ-007 The block SHALL have port smp_valid, input, 1 bit: vec_in and out_in hold a valid sample this cycle.
REQ-008 The block SHALL have port vec_in, input, IN_W bits: primary-input vector applied to the monitored sub-circuit.
REQ-009 The block SHALL have port out_in, input, 1 bit: monitored sub-circuit output for vec_in.
REQ-010 The block SHALL have port res_ready, input, 1 bit: consumer accepts the result.
REQ-011 The block SHALL have port res_valid, output, 1 bit: result registers are valid.
REQ-012 The block SHALL have port in_toggles, output, CNT_W bits: total input bit transitions in the window.
REQ-013 The block SHALL have port out_toggles, output, CNT_W bits: output transitions in the window.
REQ-014 The block SHALL have port ones_cnt, output, CNT_W bits: samples with out_in=1.
REQ-015 The block SHALL have port busy, output, 1 bit: high when the FSM is not IDLE.

Function
REQ-016 The FSM SHALL have states IDLE, PRIME, COUNT, HOLD; busy=1 in PRIME, COUNT and HOLD.
REQ-017 In IDLE, start=1 with win_len!=0 SHALL latch win_len, clear all counters and the sample count, and go to PRIME next cycle.
REQ-018 In IDLE, start=1 with win_len=0 SHALL be ignored.
REQ-019 start SHALL be ignored in any state other than IDLE.
REQ-020 In PRIME, a cycle with smp_valid=1 SHALL store vec_in/out_in as the previous sample, set sample count=1, and add out_in to ones_cnt; no toggles are counted.
REQ-021 If the latched win_len=1, that PRIME sample SHALL move the FSM to HOLD; otherwise it SHALL move the FSM to COUNT.
REQ-022 In COUNT, each cycle with smp_valid=1 SHALL add popcount(vec_in XOR prev_vec) to in_toggles, add (out_in XOR prev_out) to out_toggles, add out_in to ones_cnt, increment the sample count, and replace the previous sample.
REQ-023 Cycles with smp_valid=0 SHALL change no state or counter.
REQ-024 When the sample count reaches the latched win_len, the FSM SHALL enter HOLD on the next edge and assert res_valid, giving one cycle of latency from the last sample.
REQ-025 All three counters SHALL saturate at 2^CNT_W-1 and never wrap; a partial add that would exceed the maximum SHALL clamp to it.
REQ-026 In HOLD, res_valid and all result outputs SHALL stay stable until res_valid&&res_ready.
REQ-027 On res_valid&&res_ready the FSM SHALL return to IDLE next cycle with res_valid=0; the counters SHALL keep their values until the next accepted start.
REQ-028 Samples arriving in HOLD or IDLE SHALL be ignored.
REQ-029 res_ready SHALL be ignored when res_valid=0.

Reset
REQ-030 rst_n=0 SHALL immediately force IDLE, res_valid=0, busy=0, in_toggles=out_toggles=ones_cnt=0, and clear the previous-sample and latched-win_len registers.
REQ-031 Reset asserted mid-window or in HOLD SHALL discard the partial or pending result; no res_valid SHALL appear after release until a new window completes.

Verification
REQ-032 Basic window: win_len=4, samples (vec,out)=(0000,0),(1111,1),(1111,1),(0001,0) -> res_valid one cycle after the 4th sample; in_toggles=7, out_toggles=2, ones_cnt=2.
REQ-033 Gapped samples and backpressure: repeat REQ-032 with smp_valid=0 gaps and res_ready held 0 for 5 cycles -> identical counts; outputs stable while res_valid=1; IDLE one cycle after res_ready=1.
REQ-034 Saturation: CNT_W=4, win_len=15, vec alternating 0000/1111 and out alternating 0/1 starting at 0 -> in_toggles=15 (saturated), out_toggles=14, ones_cnt=7.
REQ-035 Edge cases: start with win_len=0 -> busy stays 0; win_len=1 with a single sample (1010,1) -> in_toggles=0, out_toggles=0, ones_cnt=1; start pulsed during COUNT -> no effect.
REQ-036 Reset mid-operation: rst_n pulsed low after 2 of 4 samples -> all outputs 0 at once; a fresh 4-sample window afterwards reports only its own counts.

Source files
------------

// File: rtl/subckt_toggle_monitor.sv
// Windowed switching-activity monitor for a combinational sub-circuit:
// counts input bit toggles, output toggles and output-high samples over a
// programmable number of valid samples, then holds the result for handshake.
`timescale 1ns/1ps
module subckt_toggle_monitor #(
    parameter int unsigned IN_W  = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] win_len,
    input  logic             smp_valid,
    input  logic [IN_W-1:0]  vec_in,
    input  logic             out_in,
    input  logic             res_ready,
    output logic             res_valid,
    output logic [CNT_W-1:0] in_toggles,
    output logic [CNT_W-1:0] out_toggles,
    output logic [CNT_W-1:0] ones_cnt,
    output logic             busy
);

    localparam int unsigned PC_W  = $clog2(IN_W + 1);
    localparam int unsigned SUM_W = CNT_W + PC_W + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PRIME = 2'd1,
        S_COUNT = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [CNT_W-1:0]  r_win_len, w_win_len_nxt;
    logic [CNT_W-1:0]  r_smp_cnt, w_smp_cnt_nxt;
    logic [IN_W-1:0]   r_prev_vec, w_prev_vec_nxt;
    logic              r_prev_out, w_prev_out_nxt;
    logic [CNT_W-1:0]  r_in_tog, w_in_tog_nxt;
    logic [CNT_W-1:0]  r_out_tog, w_out_tog_nxt;
    logic [CNT_W-1:0]  r_ones, w_ones_nxt;
    logic              r_res_valid, w_res_valid_nxt;
    logic              r_busy, w_busy_nxt;
    logic [IN_W-1:0]   w_diff;
    logic [PC_W-1:0]   w_popcnt;

    // Add a small increment to a counter, clamping at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [PC_W-1:0]  b);
        logic [SUM_W-1:0] s;
        s = SUM_W'(a) + SUM_W'(b);
        if (|s[SUM_W-1:CNT_W]) return '1;
        return s[CNT_W-1:0];
    endfunction

    // Number of input bits that changed since the previous sample.
    always_comb begin
        w_diff   = vec_in ^ r_prev_vec;
        w_popcnt = '0;
        for (int unsigned i = 0; i < IN_W; i++) begin
            w_popcnt = w_popcnt + PC_W'(w_diff[i]);
        end
    end

    // Next-state and next-counter logic.
    always_comb begin
        w_state_nxt    = r_state;
        w_win_len_nxt  = r_win_len;
        w_smp_cnt_nxt  = r_smp_cnt;
        w_prev_vec_nxt = r_prev_vec;
        w_prev_out_nxt = r_prev_out;
        w_in_tog_nxt   = r_in_tog;
        w_out_tog_nxt  = r_out_tog;
        w_ones_nxt     = r_ones;

        case (r_state)
            S_IDLE: begin
                if (start && (win_len != '0)) begin
                    w_win_len_nxt = win_len;
                    w_smp_cnt_nxt = '0;
                    w_in_tog_nxt  = '0;
                    w_out_tog_nxt = '0;
                    w_ones_nxt    = '0;
                    w_state_nxt   = S_PRIME;
                end
            end
            S_PRIME: begin
                // First sample only seeds the history; nothing to compare against yet.
                if (smp_valid) begin
                    w_prev_vec_nxt = vec_in;
                    w_prev_out_nxt = out_in;
                    w_smp_cnt_nxt  = CNT_W'(1);
                    w_ones_nxt     = sat_add(r_ones, PC_W'(out_in));
                    w_state_nxt    = (r_win_len == CNT_W'(1)) ? S_HOLD : S_COUNT;
                end
            end
            S_COUNT: begin
                if (smp_valid) begin
                    w_in_tog_nxt   = sat_add(r_in_tog, w_popcnt);
                    w_out_tog_nxt  = sat_add(r_out_tog, PC_W'(out_in ^ r_prev_out));
                    w_ones_nxt     = sat_add(r_ones, PC_W'(out_in));
                    w_smp_cnt_nxt  = r_smp_cnt + CNT_W'(1);
                    w_prev_vec_nxt = vec_in;
                    w_prev_out_nxt = out_in;
                    if ((r_smp_cnt + CNT_W'(1)) == r_win_len) begin
                        w_state_nxt = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (res_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        w_res_valid_nxt = (w_state_nxt == S_HOLD);
        w_busy_nxt      = (w_state_nxt != S_IDLE);
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_win_len   <= '0;
            r_smp_cnt   <= '0;
            r_prev_vec  <= '0;
            r_prev_out  <= 1'b0;
            r_in_tog    <= '0;
            r_out_tog   <= '0;
            r_ones      <= '0;
            r_res_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_win_len   <= w_win_len_nxt;
            r_smp_cnt   <= w_smp_cnt_nxt;
            r_prev_vec  <= w_prev_vec_nxt;
            r_prev_out  <= w_prev_out_nxt;
            r_in_tog    <= w_in_tog_nxt;
            r_out_tog   <= w_out_tog_nxt;
            r_ones      <= w_ones_nxt;
            r_res_valid <= w_res_valid_nxt;
            r_busy      <= w_busy_nxt;
        end
    end

    assign res_valid   = r_res_valid;
    assign in_toggles  = r_in_tog;
    assign out_toggles = r_out_tog;
    assign ones_cnt    = r_ones;
    assign busy        = r_busy;

endmodule
